// File: rtl/nes_cart_pkg.sv
// Shared constants and state encoding for the cartridge image loader.
// Covers NROM images only: no mapper, no trainer.
package nes_cart_pkg;

    localparam logic [31:0] INES_MAGIC    = 32'h4E45531A;
    localparam int          INES_HDR_LEN  = 16;
    localparam int          PRG_BANK_SIZE = 16384;
    localparam int          CHR_BANK_SIZE = 8192;

    typedef enum logic [2:0] {
        HEADER,
        PRG,
        CHR,
        DONE,
        ERROR
    } loader_state_t;

endpackage

// File: rtl/ines_header_check.sv
// Combinational validity test of one iNES header byte, given its position in the header.
// Bytes 8..15 are padding and always accepted.
module ines_header_check #(
    parameter int MAX_PRG_BANKS = 2,
    parameter int CHR_BANKS     = 1
) (
    input  logic [3:0] idx,
    input  logic [7:0] data,
    output logic       ok
);
    import nes_cart_pkg::*;

    always_comb begin
        ok = 1'b1;
        case (idx)
            4'd0: ok = (data == INES_MAGIC[31:24]);
            4'd1: ok = (data == INES_MAGIC[23:16]);
            4'd2: ok = (data == INES_MAGIC[15:8]);
            4'd3: ok = (data == INES_MAGIC[7:0]);
            4'd4: ok = (data != 8'd0) && (32'(data) <= 32'(MAX_PRG_BANKS));
            4'd5: ok = (32'(data) == 32'(CHR_BANKS));
            // Trainer present or any mapper bits set means this is not plain NROM
            4'd6: ok = (data[2] == 1'b0) && (data[7:4] == 4'd0);
            4'd7: ok = (data[7:4] == 4'd0);
            default: ok = 1'b1;
        endcase
    end

endmodule

// File: rtl/ines_loader.sv
// Streams an iNES image into cartridge PRG/CHR RAM, holding the CPU in reset until loaded.
// Header bytes are validated on the fly; a bad image parks the loader in ERROR and drains input.
module ines_loader #(
    parameter int MAX_PRG_BANKS = 2,
    parameter int CHR_BANKS     = 1
) (
    input  logic        cpu_clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [7:0]  wr_data,
    output logic        prg_we,
    output logic [14:0] prg_addr,
    output logic        chr_we,
    output logic [12:0] chr_addr,
    output logic [1:0]  prg_banks,
    output logic        mirror_v,
    output logic        hold_cpu,
    output logic        done,
    output logic        error
);
    import nes_cart_pkg::*;

    loader_state_t state_q, state_n;
    logic [14:0]   cnt_q, cnt_n;
    logic          rdy_q;
    logic          hdr_ok;
    logic          xfer;
    logic [31:0]   prg_last;

    ines_header_check #(
        .MAX_PRG_BANKS (MAX_PRG_BANKS),
        .CHR_BANKS     (CHR_BANKS)
    ) u_hdr (
        .idx  (cnt_q[3:0]),
        .data (in_data),
        .ok   (hdr_ok)
    );

    assign in_ready = rdy_q && (state_q != DONE);
    assign xfer     = in_valid && in_ready;
    assign prg_last = 32'(prg_banks) * 32'(PRG_BANK_SIZE) - 32'd1;
    assign done     = (state_q == DONE);
    assign error    = (state_q == ERROR);
    assign hold_cpu = (state_q != DONE);

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        case (state_q)
            HEADER: if (xfer) begin
                if (!hdr_ok) begin
                    state_n = ERROR;
                end else if (cnt_q[3:0] == 4'(INES_HDR_LEN - 1)) begin
                    state_n = PRG;
                    cnt_n   = 15'd0;
                end else begin
                    cnt_n = cnt_q + 15'd1;
                end
            end
            PRG: if (xfer) begin
                if ({17'd0, cnt_q} == prg_last) begin
                    state_n = CHR;
                    cnt_n   = 15'd0;
                end else begin
                    cnt_n = cnt_q + 15'd1;
                end
            end
            CHR: if (xfer) begin
                if (cnt_q[12:0] == 13'(CHR_BANK_SIZE - 1)) begin
                    state_n = DONE;
                    cnt_n   = 15'd0;
                end else begin
                    cnt_n = cnt_q + 15'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            state_q <= HEADER;
            cnt_q   <= 15'd0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            rdy_q   <= 1'b1;
        end
    end

    // Write stage: one cycle after the transfer, strobe with the counter value it was taken at
    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            prg_we    <= 1'b0;
            chr_we    <= 1'b0;
            prg_addr  <= 15'd0;
            chr_addr  <= 13'd0;
            wr_data   <= 8'd0;
            prg_banks <= 2'd0;
            mirror_v  <= 1'b0;
        end else begin
            prg_we <= 1'b0;
            chr_we <= 1'b0;
            if (xfer && state_q == PRG) begin
                prg_we   <= 1'b1;
                prg_addr <= cnt_q;
                wr_data  <= in_data;
            end
            if (xfer && state_q == CHR) begin
                chr_we   <= 1'b1;
                chr_addr <= cnt_q[12:0];
                wr_data  <= in_data;
            end
            if (xfer && state_q == HEADER && cnt_q[3:0] == 4'd4) prg_banks <= in_data[1:0];
            if (xfer && state_q == HEADER && cnt_q[3:0] == 4'd6) mirror_v  <= in_data[0];
        end
    end

endmodule

// File: tb/tb_ines_loader.sv
// Directed bench for ines_loader: valid 32k and 16k images, header rejects, gaps,
// trailing bytes and reset in the middle of a load.
module tb_ines_loader;

    logic        cpu_clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic [7:0]  wr_data;
    logic        prg_we;
    logic [14:0] prg_addr;
    logic        chr_we;
    logic [12:0] chr_addr;
    logic [1:0]  prg_banks;
    logic        mirror_v;
    logic        hold_cpu;
    logic        done;
    logic        error;

    ines_loader dut (
        .cpu_clk(cpu_clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .wr_data(wr_data), .prg_we(prg_we), .prg_addr(prg_addr),
        .chr_we(chr_we), .chr_addr(chr_addr), .prg_banks(prg_banks), .mirror_v(mirror_v),
        .hold_cpu(hold_cpu), .done(done), .error(error)
    );

    always #5 cpu_clk = ~cpu_clk;

    int checks = 0;
    int errors = 0;
    int stall_to = 0;
    logic [7:0] hdr [16];

    // Write monitor: expected address/data sequence restarts at every reset
    int prg_idx = 0, chr_idx = 0, order_err = 0;
    logic [14:0] last_prg = 15'd0;
    logic done_at_last = 1'b0, hold_at_last = 1'b1;

    always @(negedge cpu_clk) begin
        if (rst) begin
            prg_idx = 0; chr_idx = 0; last_prg = 15'd0; done_at_last = 1'b0; hold_at_last = 1'b1;
        end else begin
            if (prg_we) begin
                if (prg_addr !== 15'(prg_idx) || wr_data !== 8'(prg_idx) || chr_we || chr_idx != 0)
                    order_err++;
                last_prg = prg_addr;
                prg_idx++;
            end
            if (chr_we) begin
                if (chr_addr !== 13'(chr_idx) || wr_data !== 8'(chr_idx)) order_err++;
                if (chr_addr == 13'h1FFF) begin done_at_last = done; hold_at_last = hold_cpu; end
                chr_idx++;
            end
        end
    end

    task automatic set_hdr(input logic [7:0] b2, input logic [7:0] b4,
                           input logic [7:0] b5, input logic [7:0] b6);
        for (int i = 0; i < 16; i++) hdr[i] = 8'd0;
        hdr[0] = 8'h4E; hdr[1] = 8'h45; hdr[2] = b2; hdr[3] = 8'h1A;
        hdr[4] = b4; hdr[5] = b5; hdr[6] = b6; hdr[8] = 8'hFF;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int w;
        w = 0;
        @(negedge cpu_clk);
        if (gap && $urandom_range(0, 15) == 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 2)) @(negedge cpu_clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && w < 64) begin @(negedge cpu_clk); w++; end
        if (!in_ready) stall_to++;
        @(posedge cpu_clk);
    endtask

    task automatic send_image(input int prg_bytes, input int count, input bit gap);
        logic [7:0] b;
        for (int i = 0; i < count; i++) begin
            if (i < 16) b = hdr[i];
            else if (i < 16 + prg_bytes) b = 8'(i - 16);
            else b = 8'(i - 16 - prg_bytes);
            send_byte(b, gap);
        end
        @(negedge cpu_clk);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge cpu_clk);
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge cpu_clk);
        rst = 1'b0;
        @(posedge cpu_clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge cpu_clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %0b want 0", in_ready); end
        checks++; if ({prg_we, chr_we} !== 2'b00) begin errors++; $display("FAIL rst_we got %0b want 0", {prg_we, chr_we}); end
        checks++; if ({prg_addr, chr_addr, wr_data} !== 36'd0) begin errors++; $display("FAIL rst_addr_data got %0h want 0", {prg_addr, chr_addr, wr_data}); end
        checks++; if ({prg_banks, mirror_v} !== 3'd0) begin errors++; $display("FAIL rst_hdr_latch got %0h want 0", {prg_banks, mirror_v}); end
        checks++; if ({hold_cpu, done, error} !== 3'b100) begin errors++; $display("FAIL rst_status got %0b want 100", {hold_cpu, done, error}); end
        rst = 1'b0;
        @(negedge cpu_clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got %0b want 1", in_ready); end
    endtask

    task automatic test_valid_32k();
        int oe0, st0;
        do_reset();
        oe0 = order_err; st0 = stall_to;
        set_hdr(8'h53, 8'd2, 8'd1, 8'h01);
        send_image(32768, 16 + 32768 + 8192, 1'b0);
        @(negedge cpu_clk); #1;
        checks++; if (prg_idx != 32768) begin errors++; $display("FAIL 32k_prg_count got %0d want 32768", prg_idx); end
        checks++; if (last_prg !== 15'h7FFF) begin errors++; $display("FAIL 32k_last_prg got %0h want 7fff", last_prg); end
        checks++; if (chr_idx != 8192) begin errors++; $display("FAIL 32k_chr_count got %0d want 8192", chr_idx); end
        checks++; if (order_err != oe0) begin errors++; $display("FAIL 32k_order got %0d bad writes want 0", order_err - oe0); end
        checks++; if ({done_at_last, hold_at_last} !== 2'b10) begin errors++; $display("FAIL 32k_done_with_last got %0b want 10", {done_at_last, hold_at_last}); end
        checks++; if ({done, hold_cpu, error, in_ready} !== 4'b1000) begin errors++; $display("FAIL 32k_status got %0b want 1000", {done, hold_cpu, error, in_ready}); end
        checks++; if ({prg_banks, mirror_v} !== 3'b101) begin errors++; $display("FAIL 32k_hdr_latch got %0b want 101", {prg_banks, mirror_v}); end
        checks++; if (stall_to != st0) begin errors++; $display("FAIL 32k_stall got %0d want 0", stall_to - st0); end
    endtask

    task automatic test_bad_magic();
        int st0;
        do_reset();
        st0 = stall_to;
        set_hdr(8'h54, 8'd1, 8'd1, 8'h00);
        for (int i = 0; i < 3; i++) send_byte(hdr[i], 1'b0);
        #1;
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL magic_err_after_b2 got %0b want 1", error); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL magic_in_ready got %0b want 1", in_ready); end
        for (int i = 3; i < 80; i++) send_byte(8'(i), 1'b0);
        @(negedge cpu_clk); in_valid = 1'b0;
        @(negedge cpu_clk); #1;
        checks++; if (prg_idx + chr_idx != 0) begin errors++; $display("FAIL magic_no_writes got %0d want 0", prg_idx + chr_idx); end
        checks++; if ({error, done, hold_cpu} !== 3'b101) begin errors++; $display("FAIL magic_status got %0b want 101", {error, done, hold_cpu}); end
        checks++; if (stall_to != st0) begin errors++; $display("FAIL magic_drain got %0d stalls want 0", stall_to - st0); end
    endtask

    task automatic test_bad_flags();
        logic [7:0] b5v [3];
        logic [7:0] b6v [3];
        b5v[0] = 8'd1; b6v[0] = 8'h10;
        b5v[1] = 8'd1; b6v[1] = 8'h04;
        b5v[2] = 8'd2; b6v[2] = 8'h00;
        for (int c = 0; c < 3; c++) begin
            do_reset();
            set_hdr(8'h53, 8'd1, b5v[c], b6v[c]);
            send_image(16384, 40, 1'b0);
            @(negedge cpu_clk); #1;
            checks++; if ({error, done} !== 2'b10) begin errors++; $display("FAIL flags_case%0d_status got %0b want 10", c, {error, done}); end
            checks++; if (prg_idx != 0) begin errors++; $display("FAIL flags_case%0d_writes got %0d want 0", c, prg_idx); end
        end
    endtask

    task automatic test_reset_mid_and_reload();
        int oe0, tr_bad, tot0;
        do_reset();
        set_hdr(8'h53, 8'd1, 8'd1, 8'h00);
        send_image(16384, 16 + 5000, 1'b0);
        #1;
        checks++; if (prg_idx != 5000 || prg_we !== 1'b1) begin errors++; $display("FAIL mid_progress got %0d we %0b want 5000 we 1", prg_idx, prg_we); end
        rst = 1'b1;
        #1;
        checks++; if ({prg_we, prg_addr, wr_data} !== 24'd0) begin errors++; $display("FAIL mid_rst_write got %0h want 0", {prg_we, prg_addr, wr_data}); end
        checks++; if ({in_ready, hold_cpu, prg_banks} !== 4'b0100) begin errors++; $display("FAIL mid_rst_ctrl got %0b want 0100", {in_ready, hold_cpu, prg_banks}); end
        repeat (2) @(negedge cpu_clk);
        rst = 1'b0;
        @(posedge cpu_clk);
        oe0 = order_err;
        send_image(16384, 16 + 16384 + 8192, 1'b1);
        @(negedge cpu_clk); #1;
        checks++; if (prg_idx != 16384 || last_prg !== 15'h3FFF) begin errors++; $display("FAIL 16k_prg got %0d last %0h want 16384 last 3fff", prg_idx, last_prg); end
        checks++; if (chr_idx != 8192) begin errors++; $display("FAIL 16k_chr_count got %0d want 8192", chr_idx); end
        checks++; if (order_err != oe0) begin errors++; $display("FAIL 16k_order got %0d bad writes want 0", order_err - oe0); end
        checks++; if ({done_at_last, hold_at_last} !== 2'b10) begin errors++; $display("FAIL 16k_done_with_last got %0b want 10", {done_at_last, hold_at_last}); end
        checks++; if ({prg_banks, mirror_v, error} !== 4'b0100) begin errors++; $display("FAIL 16k_hdr_latch got %0b want 0100", {prg_banks, mirror_v, error}); end
        tot0 = prg_idx + chr_idx;
        tr_bad = 0;
        for (int k = 0; k < 17; k++) begin
            @(negedge cpu_clk);
            in_valid = 1'b1; in_data = 8'(8'hA0 + k);
            #1;
            if (in_ready !== 1'b0) tr_bad++;
        end
        @(negedge cpu_clk); in_valid = 1'b0;
        repeat (2) @(negedge cpu_clk); #1;
        checks++; if (tr_bad != 0) begin errors++; $display("FAIL trail_in_ready got %0d ready cycles want 0", tr_bad); end
        checks++; if (prg_idx + chr_idx != tot0) begin errors++; $display("FAIL trail_writes got %0d want %0d", prg_idx + chr_idx, tot0); end
        checks++; if ({done, hold_cpu} !== 2'b10) begin errors++; $display("FAIL trail_status got %0b want 10", {done, hold_cpu}); end
    endtask

    initial begin
        test_reset();
        test_valid_32k();
        test_bad_magic();
        test_bad_flags();
        test_reset_mid_and_reload();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
